// File: rtl/port_uart_tx.sv
// Serial monitor for the processor output port: every accepted change of `port`
// is queued in a small FIFO and sent out on `tx` as an 8N1 UART frame.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [7:0]               port,
  output logic                     tx,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE   = BW'(1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  txState_t      state;
  logic [7:0]    fifoMem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic [7:0]    last;
  logic [7:0]    shiftReg;
  logic [2:0]    bitIdx;
  logic [BW-1:0] baudCnt;

  logic pushReq;
  logic popReq;
  logic fifoFull;
  logic pushOk;

  // A push into a full FIFO still succeeds when the FSM frees a slot on the same edge.
  always_comb begin
    pushReq  = en && (port != last);
    fifoFull = (count == FULL_COUNT);
    popReq   = (state == IDLE) && (count != '0);
    pushOk   = pushReq && (!fifoFull || popReq);
  end

  // Change detector and FIFO; `last` follows the port even when the push is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      last     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifoMem[i] <= '0;
      end
    end else begin
      if (en) begin
        last <= port;
      end
      if (pushOk) begin
        fifoMem[wrPtr] <= port;
        wrPtr          <= wrPtr + PTR_ONE;
      end
      if (popReq) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
      if (pushReq && !pushOk) begin
        overflow <= 1'b1;
      end
      case ({pushOk, popReq})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Transmit FSM; tx and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      shiftReg <= '0;
      bitIdx   <= '0;
      baudCnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (popReq) begin
            shiftReg <= fifoMem[rdPtr];
            bitIdx   <= '0;
            baudCnt  <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (baudCnt == BAUD_LAST) begin
            baudCnt <= '0;
            tx      <= shiftReg[0];
            state   <= DATA;
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
        DATA: begin
          if (baudCnt == BAUD_LAST) begin
            baudCnt <= '0;
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shiftReg <= {1'b0, shiftReg[7:1]};
              bitIdx   <= bitIdx + 3'd1;
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
        STOP: begin
          if (baudCnt == BAUD_LAST) begin
            baudCnt <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            baudCnt <= baudCnt + BAUD_ONE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx: a background monitor decodes tx frames while
// the stimulus checks timing, FIFO behaviour, enable gating and reset.
module tb_port_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       en   = 1'b0;
  logic [7:0] port = 8'h00;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [3:0] count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rxQueue [$];
  int framingErrs = 0;
  int resetEvents = 0;

  port_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .port    (port),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow),
    .count   (count)
  );

  always #5 clk = ~clk;

  always @(negedge rst) resetEvents = resetEvents + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] portVal, input logic enVal);
    @(negedge clk);
    port = portVal;
    en   = enVal;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst  = 1'b0;
    port = 8'h00;
    en   = 1'b1;
    @(negedge clk);
    rst  = 1'b1;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while ((count !== 4'd0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_drainTimeout"}, 32'(count !== 4'd0 || busy !== 1'b0), 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic watchIdle(input string tag, input int cycles);
    int lowCycles;
    lowCycles = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1) lowCycles++;
    end
    checkOutput({tag, "_txLowCycles"}, 32'(lowCycles), 0);
  endtask

  // Frame decoder: samples each bit near the middle of its period.
  initial begin : rxMonitor
    logic [7:0] rxByte;
    logic       startOk;
    logic       stopOk;
    int         resetMark;
    rxByte = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        resetMark = resetEvents;
        repeat (2) @(negedge clk);
        startOk = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rxByte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        stopOk = (tx === 1'b1);
        if (resetEvents == resetMark) begin
          rxQueue.push_back(rxByte);
          if (!startOk || !stopOk) framingErrs++;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int         perr [10];
    logic [7:0] a5;
    logic       expBit;
    int         p;

    // Reset values with a random port.
    #1 rst = 1'b0;
    en = 1'b1;
    #1 checkOutput("t1_txAsync", 32'(tx), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      port = 8'($urandom);
    end
    @(negedge clk);
    checkOutput("t1_tx", 32'(tx), 1);
    checkOutput("t1_busy", 32'(busy), 0);
    checkOutput("t1_count", 32'(count), 0);
    checkOutput("t1_overflow", 32'(overflow), 0);
    port = 8'h00;
    rst  = 1'b1;
    watchIdle("t1", 200);
    checkOutput("t1_rxCount", 32'(rxQueue.size()), 0);

    // Single frame of 0xA5 with cycle-exact waveform.
    rxQueue.delete();
    a5 = 8'hA5;
    applyStimulus(8'hA5, 1'b1);
    @(negedge clk);
    checkOutput("t2_countAfterN", 32'(count), 1);
    checkOutput("t2_busyAfterN", 32'(busy), 0);
    checkOutput("t2_txAfterN", 32'(tx), 1);
    @(negedge clk);
    checkOutput("t2_busyAfterN1", 32'(busy), 1);
    checkOutput("t2_countAfterPop", 32'(count), 0);
    for (int i = 0; i < 10; i++) perr[i] = 0;
    for (int idx = 0; idx < 10 * CPB; idx++) begin
      if (idx > 0) @(negedge clk);
      p = idx / CPB;
      expBit = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : a5[p-1];
      if (tx !== expBit) perr[p]++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("t2_bitPeriod%0d_errs", i), 32'(perr[i]), 0);
    end
    @(negedge clk);
    checkOutput("t2_busyAtN41", 32'(busy), 0);
    checkOutput("t2_txAtN41", 32'(tx), 1);
    checkOutput("t2_rxCount", 32'(rxQueue.size()), 1);
    if (rxQueue.size() > 0) checkOutput("t2_rxData", 32'(rxQueue[0]), 32'hA5);

    // Burst of 10 values: first goes straight to TX, 8 queue, the 10th is dropped.
    rxQueue.delete();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(8'(8'h10 + k), 1'b1);
      if (k == 9) begin
        checkOutput("t3_countFull", 32'(count), 8);
        checkOutput("t3_overflowBeforeDrop", 32'(overflow), 0);
      end
    end
    @(negedge clk);
    checkOutput("t3_overflowAfterDrop", 32'(overflow), 1);
    checkOutput("t3_countAfterDrop", 32'(count), 8);
    waitDrain("t3", 2000);
    checkOutput("t3_rxCount", 32'(rxQueue.size()), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < rxQueue.size()) checkOutput($sformatf("t3_rx%0d", i), 32'(rxQueue[i]), 32'(8'h10 + i));
    end
    checkOutput("t3_overflowSticky", 32'(overflow), 1);

    // Push on the pop edge while full is accepted.
    doReset();
    checkOutput("t4_overflowCleared", 32'(overflow), 0);
    rxQueue.delete();
    for (int k = 0; k < 9; k++) applyStimulus(8'(8'h20 + k), 1'b1);
    repeat (34) @(negedge clk);
    checkOutput("t4_busyIdleGap", 32'(busy), 0);
    checkOutput("t4_countBeforePop", 32'(count), 8);
    port = 8'h29;
    @(negedge clk);
    checkOutput("t4_countAfterPushPop", 32'(count), 8);
    checkOutput("t4_overflow", 32'(overflow), 0);
    checkOutput("t4_busyAfterPop", 32'(busy), 1);
    waitDrain("t4", 3000);
    checkOutput("t4_rxCount", 32'(rxQueue.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < rxQueue.size()) checkOutput($sformatf("t4_rx%0d", i), 32'(rxQueue[i]), 32'(8'h20 + i));
    end
    checkOutput("t4_overflowFinal", 32'(overflow), 0);

    // Enable gating.
    rxQueue.delete();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    watchIdle("t5_gated", 100);
    checkOutput("t5_countGated", 32'(count), 0);
    checkOutput("t5_rxCountGated", 32'(rxQueue.size()), 0);
    applyStimulus(8'h33, 1'b1);
    @(negedge clk);
    checkOutput("t5_countEnabled", 32'(count), 1);
    waitDrain("t5", 1000);
    checkOutput("t5_rxCount", 32'(rxQueue.size()), 1);
    if (rxQueue.size() > 0) checkOutput("t5_rxData", 32'(rxQueue[0]), 32'h33);

    // Reset during DATA bit 3 with three entries queued.
    doReset();
    rxQueue.delete();
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h42, 1'b1);
    applyStimulus(8'h43, 1'b1);
    applyStimulus(8'h44, 1'b1);
    applyStimulus(8'h00, 1'b0);
    checkOutput("t6_countQueued", 32'(count), 3);
    repeat (15) @(negedge clk);
    checkOutput("t6_txDataBit3", 32'(tx), 0);
    checkOutput("t6_busyMidFrame", 32'(busy), 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("t6_txAsync", 32'(tx), 1);
    checkOutput("t6_countAsync", 32'(count), 0);
    checkOutput("t6_busyAsync", 32'(busy), 0);
    checkOutput("t6_overflowAsync", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    watchIdle("t6", 200);
    checkOutput("t6_rxCount", 32'(rxQueue.size()), 0);
    checkOutput("t6_countFinal", 32'(count), 0);

    checkOutput("framingErrs", 32'(framingErrs), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_uart_tx.md
# port_uart_tx

Serial monitor for the processor's 8-bit output `port`: detects every change of the port value, queues changed values in a small FIFO, and transmits each one as an 8N1 UART frame on a single `tx` line. Sits outside the processor core, on the receiving end of `port`, so a halted or free-running program can be observed off-chip without a parallel bus.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit. Legal range is ≥2.
- `DEPTH`, 8: number of FIFO entries. Must be a power of 2, ≥2.
- `clk`  in  1  system clock. Rising-edge active.
- `rst`  in  1  reset. Active-low and asynchronous. Every flop clears when `rst`=0.
- `en`  in  1  sampling enable. While 0, port changes are ignored. Transmission in progress continues.
- `port`  in  8  processor output port value.
- `tx`  out  1  serial output. Idles high.
- `busy`  out  1  1 when the FSM is in any state other than IDLE.
- `overflow`  out  1  sticky flag. Set when a change is dropped because the FIFO is full. Cleared only by reset.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Change detector: register `last` holds the last accepted value. Reset value is 0x00.
  - At an edge where `en`=1 and `port`≠`last`, the block requests a push of `port`.
  - `last` updates to `port` whether or not the push succeeds, so a dropped value is not retried.
- FIFO: circular, with read and write pointers that wrap modulo DEPTH.
  - A push when full is dropped and sets `overflow`. Exception: if a pop happens on the same edge, the push is accepted.
  - Simultaneous push and pop leave `count` unchanged.
  - Pop is never requested when empty.
- TX FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** `tx`=1. If `count`>0 at an edge, pop the head into the shift register, clear the bit counter and the baud counter, and go to START.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** `tx` = shift[0], sending LSB first. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7's period, go to STOP.
  - **STOP:** `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `tx` is driven from a register so it is glitch-free.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronously). The FIFO empties, the FSM goes to IDLE, and `overflow` and `last` clear. The partial frame is not resumed.
- Reset values: `tx`=1, `busy`=0, `overflow`=0, `count`=0.

## Timing
- A port change sampled at edge N is counted in the FIFO after edge N (`count` increments).
- If the FSM was IDLE, it pops at edge N+1. `tx` falls after edge N+1 and `busy` rises after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles, measured from the START edge to the IDLE return.
- Back-to-back frames have exactly 1 idle cycle (`tx`=1) between the end of STOP and the next START.
- Changes faster than one frame are buffered up to DEPTH entries. `port` held for a single cycle is captured if `en`=1.
- `overflow` rises one cycle after the edge that drops the push.
- `count` decrements on the pop edge. Push and pop can occur on the same edge.

## Test plan
1. **Reset values:** hold `rst`=0 with random `port` → `tx`=1, `busy`=0, `count`=0, `overflow`=0. Release reset with `port`=0x00 constant → no frame for 200 cycles.
2. **Single frame** (CLKS_PER_BIT=4): drive `port` 0x00→0xA5 at edge N.
   - After edge N, `count`=1.
   - After edge N+1, `tx`=0 for 4 cycles.
   - Data bits follow as 1,0,1,0,0,1,0,1, each 4 cycles.
   - `tx`=1 stop bit for 4 cycles, then `busy`=0 at N+41.
3. **Burst and overflow** (DEPTH=8): apply 10 distinct values on consecutive cycles, starting from IDLE.
   - The first value is popped to TX and the next 8 are queued.
   - The 10th is dropped and `overflow`=1.
   - Exactly 9 frames are sent, in order.
   - `overflow` stays 1 after the FIFO drains.
4. **Push with pop when full:** fill the FIFO while a frame is active, then change `port` on the same edge the FSM pops.
   - The value is accepted, `count` stays at 8, and `overflow` stays 0.
5. **Enable gating:** with `en`=0, toggle `port` 0x11→0x22→0x33 → no frames. Set `en`=1 with `port`=0x33 → exactly one frame of 0x33 is sent.
6. **Reset mid-frame:** assert `rst`=0 during DATA bit 3 of a frame with 3 entries queued.
   - `tx`=1 asynchronously and `count`=0.
   - After release with `port` unchanged from 0x00, no frames are sent.
